// File: rtl/audio_pkg.sv
// Shared audio types and helpers: I2S framing constants and sample-to-slot conversion.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package audio_pkg;

   localparam int         I2S_SLOT_WIDTH  = 16;
   localparam int         I2S_FRAME_BITS  = 32;
   localparam logic [8:0] SAMPLE_MIDPOINT = 9'h100;

   // Offset-binary 9-bit sample to a 16-bit signed, left-justified slot word.
   // Flipping the MSB re-centres the midpoint on zero; the low 7 bits pad to 16.
   function automatic logic [I2S_SLOT_WIDTH-1:0] to_i2s_word(input logic [8:0] sample);
      return {~sample[8], sample[7:0], 7'b0000000};
   endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides i_clk by 2*CLK_DIV and flags the edges it is about to make.
// Latency: o_rise/o_fall are high in the cycle before o_bclk changes level.
// Backpressure: none; free-running from reset release.
module i2s_bclk_gen #(
   parameter int CLK_DIV = 8
) (
   input  logic i_clk,
   input  logic i_reset,
   output logic o_bclk,
   output logic o_rise,
   output logic o_fall
);

   localparam int DIV_W = $clog2(CLK_DIV);

   logic [DIV_W-1:0] r_div;
   logic             r_bclk;
   logic             w_wrap;

   assign w_wrap = (r_div == DIV_W'(CLK_DIV - 1));

   // Half-period counter; bclk flips every time the counter wraps.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_div  <= '0;
         r_bclk <= 1'b0;
      end else if (w_wrap) begin
         r_div  <= '0;
         r_bclk <= ~r_bclk;
      end else begin
         r_div  <= r_div + 1'b1;
      end
   end

   assign o_bclk = r_bclk;
   assign o_rise = w_wrap & ~r_bclk;
   assign o_fall = w_wrap &  r_bclk;

endmodule

// File: rtl/i2s_sample_transmitter.sv
// I2S transmitter: one-entry sample buffer feeding a 16-bit left-justified word, same in both slots.
// Latency: sample held before a frame start has its MSB on o_sdata 2*CLK_DIV cycles after that start.
// Backpressure: o_sample_ready low while the holding register is full; it drains once per frame.
module i2s_sample_transmitter
   import audio_pkg::*;
#(
   parameter int CLK_DIV      = 8,
   parameter int SAMPLE_WIDTH = 9
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [SAMPLE_WIDTH-1:0] i_sample,
   input  logic                    i_sample_valid,
   output logic                    o_sample_ready,
   output logic                    o_bclk,
   output logic                    o_lrclk,
   output logic                    o_sdata,
   output logic                    o_frame_pulse,
   output logic                    o_underrun
);

   localparam int CNT_W = $clog2(I2S_FRAME_BITS);

   logic                      w_rise;
   logic                      w_fall;
   logic                      w_frame_start;
   logic [CNT_W-1:0]          w_next_cnt;
   logic [3:0]                w_bit_idx;
   logic                      w_next_sdata;

   logic [CNT_W-1:0]          r_bit_cnt;
   logic                      r_hold_vld;
   logic [I2S_SLOT_WIDTH-1:0] r_hold_word;
   logic [I2S_SLOT_WIDTH-1:0] r_word;
   logic                      r_sdata;
   logic                      r_frame_pulse;
   logic                      r_underrun;

   i2s_bclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_bclk_gen (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .o_bclk  (o_bclk),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   // A frame begins on the falling bclk edge that wraps the bit counter to 0.
   assign w_frame_start = w_fall && (r_bit_cnt == CNT_W'(I2S_FRAME_BITS - 1));
   assign w_next_cnt    = r_bit_cnt + 1'b1;

   // Pick the word bit for the slot position about to be entered: MSB one bit after LRCLK moves.
   always_comb begin
      w_bit_idx    = 4'd0;
      w_next_sdata = 1'b0;
      if (w_next_cnt == '0) begin
         w_next_sdata = 1'b0;
      end else if (w_next_cnt <= CNT_W'(I2S_SLOT_WIDTH)) begin
         w_bit_idx    = 4'(6'd16 - {1'b0, w_next_cnt});
         w_next_sdata = r_word[w_bit_idx];
      end else begin
         w_bit_idx    = 4'(6'd32 - {1'b0, w_next_cnt});
         w_next_sdata = r_word[w_bit_idx];
      end
   end

   // Rise and fall can never coincide; bit timing relies on that.
   always_comb begin
      assert (!(w_rise && w_fall));
   end

   // Bit position and serial data advance together on bclk falling edges.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_bit_cnt <= CNT_W'(I2S_FRAME_BITS - 1);
         r_sdata   <= 1'b0;
      end else if (w_fall) begin
         r_bit_cnt <= w_next_cnt;
         r_sdata   <= w_next_sdata;
      end
   end

   // Single-entry holding register: drained at frame start, refilled when empty.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_hold_vld  <= 1'b0;
         r_hold_word <= '0;
      end else if (w_frame_start && r_hold_vld) begin
         r_hold_vld  <= 1'b0;
      end else if (i_sample_valid && !r_hold_vld) begin
         r_hold_vld  <= 1'b1;
         r_hold_word <= to_i2s_word(i_sample);
      end
   end

   // Frame word: takes the held sample at frame start, otherwise the last word repeats.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_word <= to_i2s_word(SAMPLE_MIDPOINT);
      end else if (w_frame_start && r_hold_vld) begin
         r_word <= r_hold_word;
      end
   end

   // Per-frame strobes, visible in the same cycle the new frame word is in place.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_frame_pulse <= 1'b0;
         r_underrun    <= 1'b0;
      end else begin
         r_frame_pulse <= w_frame_start;
         r_underrun    <= w_frame_start && !r_hold_vld;
      end
   end

   assign o_sample_ready = ~r_hold_vld;
   assign o_lrclk        = r_bit_cnt[CNT_W-1];
   assign o_sdata        = r_sdata;
   assign o_frame_pulse  = r_frame_pulse;
   assign o_underrun     = r_underrun;

endmodule

// File: tb/tb_i2s_sample_transmitter.sv
// Bench for i2s_sample_transmitter: cycle-by-cycle comparison against a frame-level model.
// Latency: not applicable.
// Backpressure: stimulus holds valid until o_sample_ready accepts it.
module tb_i2s_sample_transmitter;

   localparam int D     = 2;
   localparam int BIT   = 2 * D;
   localparam int FRAME = 64 * D;

   logic       clk = 1'b0;
   logic       rst;
   logic [8:0] smp;
   logic       vld;
   logic       o_sample_ready, o_bclk, o_lrclk, o_sdata, o_frame_pulse, o_underrun;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   i2s_sample_transmitter #(
      .CLK_DIV      (D),
      .SAMPLE_WIDTH (9)
   ) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_sample       (smp),
      .i_sample_valid (vld),
      .o_sample_ready (o_sample_ready),
      .o_bclk         (o_bclk),
      .o_lrclk        (o_lrclk),
      .o_sdata        (o_sdata),
      .o_frame_pulse  (o_frame_pulse),
      .o_underrun     (o_underrun)
   );

   // ---------------- reference model ----------------
   int          t = 0;          // clock edges since reset release
   bit          m_hold_full = 1'b0;
   logic [15:0] m_hold_word = '0;
   logic [15:0] m_word = '0;
   bit          m_fp = 1'b0;
   bit          m_ur = 1'b0;

   // Offset-binary sample to signed amplitude scaled into the top of 16 bits.
   function automatic logic [15:0] conv(input logic [8:0] s);
      int v;
      v = (int'(s) - 256) * 128;
      return 16'(v);
   endfunction

   always @(posedge clk or posedge rst) begin : model
      bit rdy;
      if (rst) begin
         t = 0; m_hold_full = 0; m_hold_word = '0; m_word = '0; m_fp = 0; m_ur = 0;
      end else begin
         rdy  = !m_hold_full;
         t    = t + 1;
         m_fp = ((t % FRAME) == BIT);
         m_ur = 1'b0;
         if (m_fp) begin
            if (m_hold_full) begin
               m_word = m_hold_word;
               m_hold_full = 1'b0;
            end else begin
               m_ur = 1'b1;
            end
         end
         if (vld && rdy) begin
            m_hold_word = conv(smp);
            m_hold_full = 1'b1;
         end
      end
   end

   // Outputs implied by elapsed time and the current frame word.
   function automatic logic [5:0] expect_out();
      int k;
      bit sd;
      k = (31 + t / BIT) % 32;
      if (k == 0)       sd = 1'b0;
      else if (k <= 16) sd = m_word[16 - k];
      else              sd = m_word[32 - k];
      return {1'((t / D) % 2), 1'(k >= 16), sd, !m_hold_full, m_fp, m_ur};
   endfunction

   always @(negedge clk) begin : compare
      logic [5:0] e, a;
      e = expect_out();
      a = {o_bclk, o_lrclk, o_sdata, o_sample_ready, o_frame_pulse, o_underrun};
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL cycle_outputs t=%0d bclk/lr/sd/rdy/fp/ur got=%b expected=%b", t, a, e);
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s timed out", name);
   endtask

   task automatic wait_fp(output bit ur);
      bit seen;
      seen = 0;
      ur   = 0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (o_frame_pulse) begin
            seen = 1;
            break;
         end
      end
      if (!seen) timeout("wait_frame_pulse");
      else ur = o_underrun;
   endtask

   // Called at a frame-pulse negedge; collects slot bits k=1..16.
   task automatic cap_word(output logic [15:0] w);
      w = '0;
      for (int k = 1; k <= 16; k++) begin
         repeat (BIT) @(negedge clk);
         w[16 - k] = o_sdata;
      end
   endtask

   task automatic send(input logic [8:0] s);
      bit ok;
      ok  = 0;
      smp = s;
      vld = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if (o_sample_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) timeout("send_ready");
      @(negedge clk);
      vld = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      #1 rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      int          n;
      bit          ur, prev, seen;
      logic [15:0] w, wb;
      rst = 1'b1;
      vld = 1'b0;
      smp = '0;
      repeat (3) @(negedge clk);

      // 1. reset values, frame timing, bclk period
      chk("reset_outputs", {o_bclk, o_lrclk, o_sdata, o_sample_ready, o_frame_pulse, o_underrun}, 6'b010100);
      #1 rst = 1'b0;
      n = 0; seen = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk); n++;
         if (o_frame_pulse) begin seen = 1; break; end
      end
      if (!seen) timeout("first_frame");
      chk("first_frame_cycle", n, 4);
      chk("first_frame_underrun", o_underrun, 1);
      n = 0; seen = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk); n++;
         if (o_frame_pulse) begin seen = 1; break; end
      end
      if (!seen) timeout("second_frame");
      chk("frame_period", n, FRAME);
      prev = o_bclk; seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (o_bclk && !prev) begin seen = 1; break; end
         prev = o_bclk;
      end
      n = 0; prev = o_bclk; seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); n++;
         if (o_bclk && !prev) begin seen = 1; break; end
         prev = o_bclk;
      end
      if (!seen) timeout("bclk_rise");
      chk("bclk_period", n, BIT);

      // 2. full-scale positive sample
      do_reset();
      send(9'h1FF);
      wait_fp(ur); chk("t2_underrun", ur, 0);
      cap_word(w); chk("t2_word_1FF", w, 16'h7F80);

      // 3. full-scale negative then silence
      send(9'h000);
      wait_fp(ur); chk("t3_underrun_a", ur, 0);
      cap_word(w); chk("t3_word_000", w, 16'h8000);
      send(9'h100);
      wait_fp(ur); chk("t3_underrun_b", ur, 0);
      cap_word(w); chk("t3_word_100", w, 16'h0000);

      // 4. underrun repeats last word; valid exactly at frame start waits a frame
      send(9'h1FF);
      wait_fp(ur); cap_word(w); chk("t4_word_a", w, 16'h7F80);
      wait_fp(ur); chk("t4_underrun_b", ur, 1);
      fork
         cap_word(wb);
         begin
            repeat (FRAME - 1) @(negedge clk);
            smp = 9'h000; vld = 1'b1;
            @(negedge clk);
            vld = 1'b0;
         end
      join
      chk("t4_word_b_repeat", wb, 16'h7F80);
      chk("t4_pulse_c", o_frame_pulse, 1);
      chk("t4_underrun_c", o_underrun, 1);
      cap_word(w); chk("t4_word_c_repeat", w, 16'h7F80);
      wait_fp(ur); chk("t4_underrun_d", ur, 0);
      cap_word(w); chk("t4_word_d", w, 16'h8000);

      // 5. two samples in one frame: second stalls until the next frame start
      send(9'h0AA);
      smp = 9'h155; vld = 1'b1; seen = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (o_sample_ready) begin seen = 1; break; end
      end
      if (!seen) timeout("t5_stall");
      chk("t5_ready_with_frame", o_frame_pulse, 1);
      fork
         cap_word(w);
         begin @(negedge clk); vld = 1'b0; end
      join
      chk("t5_word_first", w, 16'hD500);
      wait_fp(ur); chk("t5_underrun", ur, 0);
      cap_word(w); chk("t5_word_second", w, 16'h2A80);

      // 6. reset mid-frame drops the pending sample
      wait_fp(ur);
      send(9'h1FF);
      repeat (BIT * 9 - 1) @(negedge clk);
      #1 rst = 1'b1;
      #1 chk("t6_reset_immediate", {o_bclk, o_lrclk, o_sdata, o_sample_ready, o_frame_pulse, o_underrun}, 6'b010100);
      @(negedge clk);
      #1 rst = 1'b0;
      wait_fp(ur); chk("t6_underrun", ur, 1);
      cap_word(w); chk("t6_word_silence", w, 16'h0000);

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
